// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and
// the table bit-index helper (channel-major layout, one DEPTH-wide row per channel).
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

  function automatic int unsigned tt_bit(input int unsigned ch,
                                         input int unsigned p,
                                         input int unsigned depth);
    return ch * depth + p;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_counter.sv
// Pattern index and per-pattern hold counter for the sweeper.
// The index is one bit wider than the pattern so the last-pattern test never aliases.
module sweep_counter
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN        = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            hold_step,
  input  logic            advance,
  output logic [N_IN-1:0] pattern,
  output logic            hold_last,
  output logic            idx_last
);

  localparam int DEPTH = 2 ** N_IN;
  localparam int HW    = $clog2(HOLD_CYCLES + 1);

  logic [N_IN:0] idx;
  logic [HW-1:0] hold_cnt;

  // clear has priority so an abort or a new start always lands on pattern 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      hold_cnt <= '0;
    end else if (clear) begin
      idx      <= '0;
      hold_cnt <= '0;
    end else if (advance) begin
      idx      <= idx + 1'b1;
      hold_cnt <= '0;
    end else if (hold_step) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign pattern   = idx[N_IN-1:0];
  assign idx_last  = (idx == (N_IN + 1)'(DEPTH - 1));
  assign hold_last = (hold_cnt == HW'(HOLD_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks every input pattern, captures each output
// channel into a truth table and flags the first pattern that disagrees with exp_table.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN        = 4,
  parameter int N_OUT       = 1,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [N_OUT-1:0]         dut_out,
  input  logic [N_OUT*2**N_IN-1:0] exp_table,
  output logic [N_IN-1:0]          dut_in,
  output logic                     busy,
  output logic                     done,
  output logic [N_OUT*2**N_IN-1:0] table_out,
  output logic                     mismatch,
  output logic [N_IN-1:0]          first_bad
);

  localparam int DEPTH = 2 ** N_IN;

  sweep_state_t state;

  logic                   start_ok;
  logic                   cnt_clear;
  logic                   cnt_hold_step;
  logic                   cnt_advance;
  logic [N_IN-1:0]        pattern;
  logic                   hold_last;
  logic                   idx_last;
  logic [DEPTH-1:0]       pat_onehot;
  logic [N_OUT-1:0]       chan_diff;
  logic [N_OUT*DEPTH-1:0] table_next;

  assign start_ok      = (state == ST_IDLE) && start && !abort;
  assign cnt_clear     = start_ok || (abort && (state != ST_IDLE));
  assign cnt_hold_step = (state == ST_DRIVE) && !abort;
  assign cnt_advance   = (state == ST_SAMPLE) && !abort && !idx_last;

  sweep_counter #(
    .N_IN        (N_IN),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (cnt_clear),
    .hold_step (cnt_hold_step),
    .advance   (cnt_advance),
    .pattern   (pattern),
    .hold_last (hold_last),
    .idx_last  (idx_last)
  );

  // One-hot column select keeps every table access at a constant row offset
  assign pat_onehot = {{(DEPTH - 1){1'b0}}, 1'b1} << pattern;

  for (genvar ch = 0; ch < N_OUT; ch++) begin : g_chan
    localparam int BASE = tt_bit(ch, 0, DEPTH);
    logic [DEPTH-1:0] exp_row;
    logic [DEPTH-1:0] cap_row;
    assign exp_row       = exp_table[BASE +: DEPTH];
    assign cap_row       = table_out[BASE +: DEPTH];
    assign chan_diff[ch] = dut_out[ch] != (|(exp_row & pat_onehot));
    assign table_next[BASE +: DEPTH] = dut_out[ch] ? (cap_row | pat_onehot)
                                                   : (cap_row & ~pat_onehot);
  end

  // Abort is checked ahead of the SAMPLE capture so a coinciding capture is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
      mismatch  <= 1'b0;
      first_bad <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state     <= ST_DRIVE;
            busy      <= 1'b1;
            dut_in    <= '0;
            table_out <= '0;
            mismatch  <= 1'b0;
            first_bad <= '0;
          end
        end
        ST_DRIVE: begin
          if (abort) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            dut_in <= '0;
          end else if (hold_last) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            dut_in <= '0;
          end else begin
            table_out <= table_next;
            if ((|chan_diff) && !mismatch) begin
              mismatch  <= 1'b1;
              first_bad <= pattern;
            end
            if (idx_last) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state  <= ST_DRIVE;
              dut_in <= pattern + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          if (abort) begin
            dut_in <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
